// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score logic: BCD digit types,
// the default winning scores and a BCD-to-binary helper for the win compare.
package pong_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } score_t;

    localparam bcd_t BCD_MAX          = 4'd9;
    localparam int   WIN_SCORE_LO_DEF = 11;
    localparam int   WIN_SCORE_HI_DEF = 15;

    // Binary value of a two-digit score, clamped to 31 so it fits the 5-bit compare.
    function automatic logic [4:0] score_to_bin(input score_t s);
        logic [6:0] v;
        v = (7'(s.tens) * 7'd10) + 7'(s.ones);
        return (v > 7'd31) ? 5'd31 : v[4:0];
    endfunction

endpackage

// File: rtl/bcd_score_digits.sv
// Two-digit BCD score counter for one player: clears on CLR, counts on INC
// and holds at 99 instead of wrapping.
module bcd_score_digits
    import pong_pkg::*;
(
    input  logic       CLK_DRV,
    input  logic       FPGA_RESET_N,
    input  logic       CLR,
    input  logic       INC,
    output logic [3:0] TENS,
    output logic [3:0] ONES
);

    bcd_t r_tens;
    bcd_t r_ones;

    always_ff @(posedge CLK_DRV or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (CLR) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (INC) begin
            if (r_ones != BCD_MAX) begin
                r_ones <= r_ones + 4'd1;
            end else if (r_tens != BCD_MAX) begin
                r_ones <= '0;
                r_tens <= r_tens + 4'd1;
            end
        end
    end

    assign TENS = r_tens;
    assign ONES = r_ones;

endmodule

// File: rtl/score_counter.sv
// Two-player score counter: synchronizes the asynchronous miss inputs, turns each
// miss into a single event, credits the opposite player and raises STOP_G on a win.
module score_counter
    import pong_pkg::*;
#(
    parameter int WIN_SCORE_LO = WIN_SCORE_LO_DEF,
    parameter int WIN_SCORE_HI = WIN_SCORE_HI_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK_DRV,
    input  logic       FPGA_RESET_N,
    input  logic       SRST,
    input  logic       MISS_N,
    input  logic       MISS_LEFT,
    input  logic       SCORE15,
    output logic [3:0] SCORE1_TENS,
    output logic [3:0] SCORE1_ONES,
    output logic [3:0] SCORE2_TENS,
    output logic [3:0] SCORE2_ONES,
    output logic       STOP_G
);

    logic [SYNC_STAGES-1:0] r_miss_n_sync;
    logic [SYNC_STAGES-1:0] r_miss_left_sync;
    logic                   r_miss_n_prev;
    logic                   r_miss_evt;
    logic                   r_miss_left;
    logic                   r_stop_g;

    logic       w_miss_n_s;
    logic       w_miss_left_s;
    logic       w_inc1;
    logic       w_inc2;
    logic [4:0] w_target;
    logic [4:0] w_bin1;
    logic [4:0] w_bin2;
    logic       w_win;

    assign w_miss_n_s    = r_miss_n_sync[SYNC_STAGES-1];
    assign w_miss_left_s = r_miss_left_sync[SYNC_STAGES-1];

    // Idle level is high everywhere so a reset never looks like a fresh miss.
    always_ff @(posedge CLK_DRV or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            r_miss_n_sync    <= '1;
            r_miss_left_sync <= '1;
            r_miss_n_prev    <= 1'b1;
            r_miss_evt       <= 1'b0;
            r_miss_left      <= 1'b1;
        end else begin
            r_miss_n_sync    <= {r_miss_n_sync[SYNC_STAGES-2:0], MISS_N};
            r_miss_left_sync <= {r_miss_left_sync[SYNC_STAGES-2:0], MISS_LEFT};
            r_miss_n_prev    <= w_miss_n_s;
            r_miss_evt       <= r_miss_n_prev & ~w_miss_n_s;
            r_miss_left      <= w_miss_left_s;
        end
    end

    // A ball leaving on the left is a point for player 2, on the right for player 1.
    assign w_inc1 = r_miss_evt & ~r_stop_g & ~r_miss_left;
    assign w_inc2 = r_miss_evt & ~r_stop_g &  r_miss_left;

    bcd_score_digits u_player1 (
        .CLK_DRV      (CLK_DRV),
        .FPGA_RESET_N (FPGA_RESET_N),
        .CLR          (SRST),
        .INC          (w_inc1),
        .TENS         (SCORE1_TENS),
        .ONES         (SCORE1_ONES)
    );

    bcd_score_digits u_player2 (
        .CLK_DRV      (CLK_DRV),
        .FPGA_RESET_N (FPGA_RESET_N),
        .CLR          (SRST),
        .INC          (w_inc2),
        .TENS         (SCORE2_TENS),
        .ONES         (SCORE2_ONES)
    );

    assign w_target = SCORE15 ? 5'(WIN_SCORE_HI) : 5'(WIN_SCORE_LO);
    assign w_bin1   = score_to_bin(score_t'{tens: SCORE1_TENS, ones: SCORE1_ONES});
    assign w_bin2   = score_to_bin(score_t'{tens: SCORE2_TENS, ones: SCORE2_ONES});
    assign w_win    = (w_bin1 >= w_target) || (w_bin2 >= w_target);

    // Powers up stopped so the machine sits in attract until a coin.
    always_ff @(posedge CLK_DRV or negedge FPGA_RESET_N) begin
        if (!FPGA_RESET_N) begin
            r_stop_g <= 1'b1;
        end else if (SRST) begin
            r_stop_g <= 1'b0;
        end else if (w_win) begin
            r_stop_g <= 1'b1;
        end
    end

    assign STOP_G = r_stop_g;

endmodule

// File: tb/tb_score_counter.sv
// Randomized scoreboard bench for score_counter: the stimulus side keeps an
// integer score model and queues every expected display change with its cycle.
module tb_score_counter;

    logic       CLK_DRV      = 1'b0;
    logic       FPGA_RESET_N = 1'b0;
    logic       SRST         = 1'b0;
    logic       MISS_N       = 1'b1;
    logic       MISS_LEFT    = 1'b0;
    logic       SCORE15      = 1'b0;
    logic [3:0] SCORE1_TENS;
    logic [3:0] SCORE1_ONES;
    logic [3:0] SCORE2_TENS;
    logic [3:0] SCORE2_ONES;
    logic       STOP_G;

    score_counter dut (
        .CLK_DRV      (CLK_DRV),
        .FPGA_RESET_N (FPGA_RESET_N),
        .SRST         (SRST),
        .MISS_N       (MISS_N),
        .MISS_LEFT    (MISS_LEFT),
        .SCORE15      (SCORE15),
        .SCORE1_TENS  (SCORE1_TENS),
        .SCORE1_ONES  (SCORE1_ONES),
        .SCORE2_TENS  (SCORE2_TENS),
        .SCORE2_ONES  (SCORE2_ONES),
        .STOP_G       (STOP_G)
    );

    always #5 CLK_DRV = ~CLK_DRV;

    int edge_cnt = 0;
    always @(posedge CLK_DRV) edge_cnt++;

    typedef struct {
        int          cyc;
        logic [16:0] st;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: plain integer scores, a stop flag and the target selector.
    int          m_p1   = 0;
    int          m_p2   = 0;
    bit          m_stop = 1'b1;
    bit          m_sel  = 1'b0;
    logic [16:0] m_last = 17'h00001;

    function automatic logic [16:0] m_state();
        return {4'(m_p1 / 10), 4'(m_p1 % 10), 4'(m_p2 / 10), 4'(m_p2 % 10), m_stop};
    endfunction

    function automatic void m_push(input int cyc);
        logic [16:0] st;
        st = m_state();
        if (st !== m_last) begin
            exp_q.push_back('{cyc, st});
            m_last = st;
        end
    endfunction

    function automatic bit m_win();
        int target;
        target = m_sel ? 15 : 11;
        return (m_p1 >= target) || (m_p2 >= target);
    endfunction

    // Monitor: every display change must match the head of the queue, on time.
    logic [16:0] prev  = 17'h00001;
    logic [16:0] obs;
    bit          first = 1'b1;

    always @(negedge CLK_DRV) begin
        obs = {SCORE1_TENS, SCORE1_ONES, SCORE2_TENS, SCORE2_ONES, STOP_G};
        if (first) begin
            first = 1'b0;
            n_cmp++;
            if (obs !== 17'h00001) begin
                n_err++;
                $display("FAIL reset_state: got %h want %h", obs, 17'h00001);
            end
            prev = obs;
        end else if (obs !== prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change @%0d: got %h (was %h), nothing expected",
                         edge_cnt, obs, prev);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.st !== obs || mon_e.cyc != edge_cnt) begin
                    n_err++;
                    $display("FAIL display_update: got %h @%0d want %h @%0d",
                             obs, edge_cnt, mon_e.st, mon_e.cyc);
                end else begin
                    $display("ok   update @%0d p1=%0d%0d p2=%0d%0d stop=%0b", edge_cnt,
                             obs[16:13], obs[12:9], obs[8:5], obs[4:1], obs[0]);
                end
            end
            prev = obs;
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
            n_cmp++;
            n_err++;
            mon_e = exp_q.pop_front();
            $display("FAIL missing_update @%0d: got %h want %h @%0d",
                     edge_cnt, obs, mon_e.st, mon_e.cyc);
        end
    end

    task automatic step();
        @(posedge CLK_DRV);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_miss(input bit left, input int hold, input int gap);
        int f;
        step();
        MISS_LEFT = left;
        MISS_N    = 1'b0;
        f         = edge_cnt;
        if (!m_stop) begin
            if (left) m_p2 = (m_p2 < 99) ? m_p2 + 1 : 99;
            else      m_p1 = (m_p1 < 99) ? m_p1 + 1 : 99;
            m_push(f + 4);
            if (m_win()) begin
                m_stop = 1'b1;
                m_push(f + 5);
            end
        end
        idle(hold);
        MISS_N = 1'b1;
        idle(gap);
    endtask

    task automatic srst_pulse();
        step();
        SRST   = 1'b1;
        m_p1   = 0;
        m_p2   = 0;
        m_stop = 1'b0;
        m_push(edge_cnt + 1);
        step();
        SRST = 1'b0;
    endtask

    task automatic set_score15(input bit v);
        step();
        SCORE15 = v;
        m_sel   = v;
        if (!m_stop && m_win()) begin
            m_stop = 1'b1;
            m_push(edge_cnt + 1);
        end
    endtask

    // Miss whose event lands on the same edge as SRST: cleared, not counted.
    task automatic miss_with_srst();
        step();
        MISS_LEFT = 1'b0;
        MISS_N    = 1'b0;
        idle(3);
        SRST   = 1'b1;
        m_p1   = 0;
        m_p2   = 0;
        m_stop = 1'b0;
        m_push(edge_cnt + 1);
        step();
        SRST = 1'b0;
        idle(2);
        MISS_N = 1'b1;
        idle(3);
    endtask

    // Power-on reset while a miss is still in the synchronizer.
    task automatic reset_mid_count();
        step();
        MISS_LEFT = 1'b1;
        MISS_N    = 1'b0;
        idle(2);
        FPGA_RESET_N = 1'b0;
        MISS_N       = 1'b1;
        m_p1         = 0;
        m_p2         = 0;
        m_stop       = 1'b1;
        m_push(edge_cnt);
        idle(2);
        FPGA_RESET_N = 1'b1;
        idle(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        FPGA_RESET_N = 1'b1;
        do_miss(1'b0, 3, 3);
        do_miss(1'b1, 2, 3);
        idle(4);

        srst_pulse();
        idle(3);
        do_miss(1'b1, 50, 3);
        idle(6);
        for (int i = 0; i < 10; i++) do_miss(1'b0, 2, 3);
        idle(6);
        do_miss(1'b0, 1, 2);
        do_miss(1'b0, 2, 2);
        idle(6);

        srst_pulse();
        set_score15(1'b1);
        for (int i = 0; i < 12; i++) do_miss(1'b1, $urandom_range(1, 4), $urandom_range(1, 3));
        idle(6);
        set_score15(1'b0);
        idle(6);

        srst_pulse();
        for (int i = 0; i < 3; i++) do_miss(1'b0, 2, 2);
        idle(6);
        miss_with_srst();
        idle(4);
        do_miss(1'b1, 2, 2);
        do_miss(1'b1, 2, 2);
        idle(6);
        reset_mid_count();

        srst_pulse();
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                idle(6);
                srst_pulse();
            end else if (r == 1) begin
                idle(6);
                set_score15(1'($urandom_range(0, 1)));
                idle(2);
            end else begin
                do_miss(1'($urandom_range(0, 1)), $urandom_range(1, 5), $urandom_range(1, 4));
            end
        end
        idle(10);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_updates: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
